field_unpacker: RTL and testbench



---
 rtl/field_unpacker.sv | 121 ++++++++++++
 tb/tb_field_unpacker.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/field_unpacker.sv
// field_unpacker
//   Streaming unpacker for words built MSB-first as {f0, f1, ..., fN-1}.
//   It emits one field per output handshake, zero- or sign-extended to OUT_W.
//
//   Optional feature macro: FIELD_UNPACKER_BACK2BACK_EN
//     defined   : a new word can be accepted in the same cycle as the
//                 last-field handshake, so there is no bubble between words.
//     undefined : a new word is accepted only in IDLE, which leaves at least
//                 one out_valid=0 cycle between words.
//
// Ports
//   clk, rst         clock; synchronous active-high reset
//   in_valid/ready   input word handshake
//   in_data          packed word; f0 at [IN_W-1 -: FIELD_W]
//   in_count         fields present, counted from the MSB end (0 = empty word)
//   in_sext          1 = sign-extend, 0 = zero-extend
//   out_valid/ready  output field handshake
//   out_data         extended field
//   out_idx          field index within its word (0 = MSB field)
//   out_last         current field is the last of its word
module field_unpacker #(
  parameter int FIELD_W    = 4,
  parameter int NUM_FIELDS = 4,
  parameter int OUT_W      = 8,
  localparam int IN_W  = FIELD_W*NUM_FIELDS,
  localparam int IDX_W = $clog2(NUM_FIELDS),
  localparam int CNT_W = $clog2(NUM_FIELDS+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic [CNT_W-1:0] in_count,
  input  logic             in_sext,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last
);

  typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

  state_t           state, state_d;
  logic [IN_W-1:0]  sreg;
  logic             sext_q;
  logic [CNT_W-1:0] cnt_q;
  logic [IDX_W-1:0] idx_q;

  logic             in_fire, out_fire;
  logic [CNT_W-1:0] cnt_in;
  logic [FIELD_W-1:0] fld;

  // Counts larger than the word can hold are clamped to a full word.
  assign cnt_in = (in_count > CNT_W'(NUM_FIELDS)) ? CNT_W'(NUM_FIELDS) : in_count;

  // The current field always sits at the top of sreg.
  assign fld = sreg[IN_W-1 -: FIELD_W];

  generate
    if (OUT_W > FIELD_W) begin : g_ext
      assign out_data = sext_q ? {{(OUT_W-FIELD_W){fld[FIELD_W-1]}}, fld}
                               : {{(OUT_W-FIELD_W){1'b0}}, fld};
    end else begin : g_noext
      assign out_data = fld;
    end
  endgenerate

  assign out_idx  = idx_q;
  assign out_last = (state == EMIT) && (CNT_W'(idx_q) == cnt_q - CNT_W'(1));
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_comb begin
    state_d   = state;
    out_valid = (state == EMIT);
`ifdef FIELD_UNPACKER_BACK2BACK_EN
    in_ready  = (state == IDLE) || (out_last && out_ready);
`else
    in_ready  = (state == IDLE);
`endif
    case (state)
      IDLE: if (in_fire && (in_count != '0)) state_d = EMIT;
      EMIT: begin
        if (out_fire && out_last) begin
          state_d = IDLE;
`ifdef FIELD_UNPACKER_BACK2BACK_EN
          // The next word goes straight back into EMIT unless it is empty.
          if (in_fire && (in_count != '0)) state_d = EMIT;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      sreg   <= '0;
      sext_q <= 1'b0;
      cnt_q  <= '0;
      idx_q  <= '0;
    end else begin
      state <= state_d;
      // A load can only coincide with the last-field handshake, so it takes
      // priority over the shift.
      if (in_fire) begin
        sreg   <= in_data;
        sext_q <= in_sext;
        cnt_q  <= cnt_in;
        idx_q  <= '0;
      end else if (out_fire && !out_last) begin
        sreg  <= sreg << FIELD_W;
        idx_q <= idx_q + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_field_unpacker.sv
// Directed testbench for field_unpacker with the default parameters
// (FIELD_W=4, NUM_FIELDS=4, OUT_W=8).
module tb_field_unpacker;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_sext, out_valid, out_ready, out_last;
  logic [15:0] in_data;
  logic [2:0]  in_count;
  logic [7:0]  out_data;
  logic [1:0]  out_idx;

  int passed = 0;
  int total  = 0;

  field_unpacker dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_count(in_count), .in_sext(in_sext),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Checks the field on the bus now, then advances one cycle.
  task automatic fld(input string tag, input logic [7:0] d, input logic [1:0] i, input logic l);
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".data"},  32'(out_data),  32'(d));
    chk({tag, ".idx"},   32'(out_idx),   32'(i));
    chk({tag, ".last"},  32'(out_last),  32'(l));
    tick();
  endtask

  task automatic send(input logic [15:0] d, input logic [2:0] c, input logic s);
    in_valid = 1'b1; in_data = d; in_count = c; in_sext = s;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_count = '0; in_sext = 1'b0;
    out_ready = 1'b1;
    tick(); tick();
    chk("rst.in_ready",  32'(in_ready),  32'd1);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.out_data",  32'(out_data),  32'd0);
    chk("rst.out_idx",   32'(out_idx),   32'd0);
    chk("rst.out_last",  32'(out_last),  32'd0);
    rst = 1'b0;
    tick();

    // Zero-extend, full word
    send(16'hA5F3, 3'd4, 1'b0);
    chk("zext.in_ready_busy", 32'(in_ready), 32'd0);
    fld("zext0", 8'h0A, 2'd0, 1'b0);
    fld("zext1", 8'h05, 2'd1, 1'b0);
    fld("zext2", 8'h0F, 2'd2, 1'b0);
    fld("zext3", 8'h03, 2'd3, 1'b1);
    chk("zext.end_valid", 32'(out_valid), 32'd0);
    chk("zext.end_ready", 32'(in_ready),  32'd1);

    // Sign-extend, same word
    send(16'hA5F3, 3'd4, 1'b1);
    fld("sext0", 8'hFA, 2'd0, 1'b0);
    fld("sext1", 8'h05, 2'd1, 1'b0);
    fld("sext2", 8'hFF, 2'd2, 1'b0);
    fld("sext3", 8'h03, 2'd3, 1'b1);
    chk("sext.end_valid", 32'(out_valid), 32'd0);

    // Partial word: two fields, trailing fields never emitted
    send(16'h7C00, 3'd2, 1'b1);
    fld("part0", 8'h07, 2'd0, 1'b0);
    fld("part1", 8'hFC, 2'd1, 1'b1);
    chk("part.end_valid", 32'(out_valid), 32'd0);
    tick();
    chk("part.no_more", 32'(out_valid), 32'd0);

    // Empty word is consumed silently
    send(16'hFFFF, 3'd0, 1'b0);
    chk("empty.in_ready",  32'(in_ready),  32'd1);
    chk("empty.out_valid", 32'(out_valid), 32'd0);
    tick();
    chk("empty.out_valid2", 32'(out_valid), 32'd0);

    // Count above NUM_FIELDS clamps to a full word
    send(16'h1234, 3'd7, 1'b0);
    fld("clamp0", 8'h01, 2'd0, 1'b0);
    fld("clamp1", 8'h02, 2'd1, 1'b0);
    fld("clamp2", 8'h03, 2'd2, 1'b0);
    fld("clamp3", 8'h04, 2'd3, 1'b1);
    chk("clamp.end_valid", 32'(out_valid), 32'd0);

    // Backpressure on field 1
    send(16'h1234, 3'd4, 1'b0);
    fld("bp0", 8'h01, 2'd0, 1'b0);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("bp.hold_valid", 32'(out_valid), 32'd1);
      chk("bp.hold_data",  32'(out_data),  32'h02);
      chk("bp.hold_idx",   32'(out_idx),   32'd1);
      chk("bp.hold_last",  32'(out_last),  32'd0);
      chk("bp.in_ready",   32'(in_ready),  32'd0);
      tick();
    end
    out_ready = 1'b1;
    fld("bp1", 8'h02, 2'd1, 1'b0);
    fld("bp2", 8'h03, 2'd2, 1'b0);
    fld("bp3", 8'h04, 2'd3, 1'b1);

    // Reset mid-word discards the rest of the word
    send(16'hA5F3, 3'd4, 1'b0);
    fld("mrst0", 8'h0A, 2'd0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst.out_valid", 32'(out_valid), 32'd0);
    chk("mrst.in_ready",  32'(in_ready),  32'd1);
    chk("mrst.out_data",  32'(out_data),  32'd0);
    chk("mrst.out_idx",   32'(out_idx),   32'd0);
    chk("mrst.out_last",  32'(out_last),  32'd0);
    send(16'h0001, 3'd4, 1'b0);
    fld("post0", 8'h00, 2'd0, 1'b0);
    fld("post1", 8'h00, 2'd1, 1'b0);
    fld("post2", 8'h00, 2'd2, 1'b0);
    fld("post3", 8'h01, 2'd3, 1'b1);
    tick();

    // Back-to-back words with in_valid held high
    in_valid = 1'b1; in_data = 16'h1234; in_count = 3'd4; in_sext = 1'b0;
    tick();
    in_data = 16'hA5F3;
    fld("b2bA0", 8'h01, 2'd0, 1'b0);
    fld("b2bA1", 8'h02, 2'd1, 1'b0);
    fld("b2bA2", 8'h03, 2'd2, 1'b0);
    fld("b2bA3", 8'h04, 2'd3, 1'b1);
`ifndef FIELD_UNPACKER_BACK2BACK_EN
    chk("b2b.gap_valid", 32'(out_valid), 32'd0);
    chk("b2b.gap_ready", 32'(in_ready),  32'd1);
    tick();
`endif
    in_valid = 1'b0;
    fld("b2bB0", 8'h0A, 2'd0, 1'b0);
    fld("b2bB1", 8'h05, 2'd1, 1'b0);
    fld("b2bB2", 8'h0F, 2'd2, 1'b0);
    fld("b2bB3", 8'h03, 2'd3, 1'b1);
    chk("b2b.end_valid", 32'(out_valid), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
